// File: rtl/ascon_output_serializer.sv
// ASCON output serializer: buffers 64-bit ciphertext blocks and the 128-bit
// tag, then streams them as 32-bit words over valid/ready (cipher first).
//
// Ports:
//   clock_i, reset_i       clock, async active-high reset
//   cipher_en_i, cipher_i  ciphertext block capture pulse and data
//   tag_en_i, tag_i        tag capture pulse and data
//   word_o, valid_o        output word and its valid flag
//   ready_i                downstream accepts word_o
//   is_tag_o, last_o       word belongs to tag / is the final tag word
//   busy_o                 data buffered or stream in progress
//   overflow_o             sticky: a block or tag was dropped
module ascon_output_serializer #(
  parameter int fifo_depth_g = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         cipher_en_i,
  input  logic [63:0]  cipher_i,
  input  logic         tag_en_i,
  input  logic [127:0] tag_i,
  output logic [31:0]  word_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         is_tag_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         overflow_o
);

  localparam int AW = (fifo_depth_g > 1) ?
                      $clog2(fifo_depth_g) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(fifo_depth_g);

  typedef enum logic [2:0] {
    IDLE,
    C_HI,
    C_LO,
    T0,
    T1,
    T2,
    T3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [63:0]   r_mem [fifo_depth_g];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic [127:0]  r_tag;
  logic          r_tag_pend;
  logic          r_ovf;

  logic          w_valid;
  logic          w_xfer;
  logic          w_pop;
  logic          w_t3_xfer;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop_c;
  logic          w_tag_cap;
  logic          w_drop_t;
  logic [63:0]   w_head;
  logic [31:0]   w_word;

  assign w_valid   = (r_state != IDLE);
  assign w_xfer    = w_valid & ready_i;
  assign w_pop     = w_xfer & (r_state == C_LO);
  assign w_t3_xfer = w_xfer & (r_state == T3);
  assign w_full    = (r_count == FULL_C);
  assign w_empty   = (r_count == '0);

  // A full FIFO still accepts a block when the head pops this cycle;
  // any block after the tag is a protocol error and is dropped.
  assign w_push    = cipher_en_i & ~r_tag_pend &
                     (~w_full | w_pop);
  assign w_drop_c  = cipher_en_i & ~w_push;

  // The T3 transfer cycle still sees the tag as pending.
  assign w_tag_cap = tag_en_i & ~r_tag_pend;
  assign w_drop_t  = tag_en_i & r_tag_pend;

  assign w_head    = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= cipher_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_tag      <= '0;
      r_tag_pend <= 1'b0;
    end else begin
      if (w_tag_cap) begin
        r_tag      <= tag_i;
        r_tag_pend <= 1'b1;
      end else if (w_t3_xfer) begin
        r_tag_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop_c | w_drop_t) begin
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // C_LO looks at next-cycle FIFO/tag status so the following block or
  // the tag starts without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = C_HI;
        end else if (r_tag_pend) begin
          w_state_nxt = T0;
        end
      end
      C_HI: begin
        if (w_xfer) begin
          w_state_nxt = C_LO;
        end
      end
      C_LO: begin
        if (w_xfer) begin
          if (w_count_nxt != '0) begin
            w_state_nxt = C_HI;
          end else if (r_tag_pend | w_tag_cap) begin
            w_state_nxt = T0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      T0: begin
        if (w_xfer) begin
          w_state_nxt = T1;
        end
      end
      T1: begin
        if (w_xfer) begin
          w_state_nxt = T2;
        end
      end
      T2: begin
        if (w_xfer) begin
          w_state_nxt = T3;
        end
      end
      T3: begin
        if (w_xfer) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_word = '0;
    unique case (r_state)
      C_HI:    w_word = w_head[63:32];
      C_LO:    w_word = w_head[31:0];
      T0:      w_word = r_tag[127:96];
      T1:      w_word = r_tag[95:64];
      T2:      w_word = r_tag[63:32];
      T3:      w_word = r_tag[31:0];
      default: w_word = '0;
    endcase
  end

  assign word_o     = w_word;
  assign valid_o    = w_valid;
  assign is_tag_o   = (r_state == T0) | (r_state == T1) |
                      (r_state == T2) | (r_state == T3);
  assign last_o     = (r_state == T3);
  assign busy_o     = ~w_empty | r_tag_pend | w_valid;
  assign overflow_o = r_ovf;

endmodule
